// File: rtl/align_add_acc_pkg.sv
// Shared widths, the tree-stage payload and the saturating adder for align_add_acc.
package align_add_acc_pkg;

    localparam int unsigned EW    = 11;
    localparam int unsigned MW    = 12;
    localparam int unsigned GW    = 4;
    localparam int unsigned AW    = MW + GW;
    localparam int unsigned ACCW  = 32;
    localparam int unsigned ACCXW = ACCW + 1;
    localparam int unsigned NLANE = 16;
    localparam int unsigned SW    = AW + 4;

    typedef struct packed {
        logic signed [SW-1:0] sum;
        logic [EW-1:0]        bexp;
        logic                 last;
    } tree_beat_t;

    // Two's-complement add clamped to the accumulator range instead of wrapping.
    function automatic logic signed [ACCW-1:0] sat_add(input logic signed [ACCW-1:0] a,
                                                       input logic signed [ACCW-1:0] b);
        logic signed [ACCW:0] s;
        s = ACCXW'(a) + ACCXW'(b);
        if (s[ACCW] != s[ACCW-1]) begin
            sat_add = s[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        end else begin
            sat_add = s[ACCW-1:0];
        end
    endfunction

endpackage

// File: rtl/align_shift.sv
// Arithmetic right shift; shift amounts at or beyond the width give pure sign fill.
module align_shift
    import align_add_acc_pkg::*;
#(
    parameter int unsigned W   = AW,
    parameter int unsigned SHW = EW
) (
    input  logic signed [W-1:0]   d,
    input  logic        [SHW-1:0] sh,
    output logic signed [W-1:0]   q_c
);

    // Saturate the shift explicitly so oversized amounts never depend on operator corner cases.
    always_comb begin
        q_c = d >>> sh;
        if (32'(sh) >= W) begin
            q_c = {W{d[W-1]}};
        end
    end

endmodule

// File: rtl/align_add_acc.sv
// Align 16 significands, sum them and accumulate block sums per group; 3-stage pipeline.
module align_add_acc
    import align_add_acc_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_last,
    input  logic signed [MW-1:0]   imant_00, imant_01, imant_02, imant_03,
    input  logic signed [MW-1:0]   imant_04, imant_05, imant_06, imant_07,
    input  logic signed [MW-1:0]   imant_08, imant_09, imant_10, imant_11,
    input  logic signed [MW-1:0]   imant_12, imant_13, imant_14, imant_15,
    input  logic        [EW-1:0]   ishift_00, ishift_01, ishift_02, ishift_03,
    input  logic        [EW-1:0]   ishift_04, ishift_05, ishift_06, ishift_07,
    input  logic        [EW-1:0]   ishift_08, ishift_09, ishift_10, ishift_11,
    input  logic        [EW-1:0]   ishift_12, ishift_13, ishift_14, ishift_15,
    input  logic        [EW-1:0]   iexp_max,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [ACCW-1:0] osum,
    output logic        [EW-1:0]   oexp
);

    logic signed [MW-1:0] mant  [NLANE];
    logic        [EW-1:0] shift [NLANE];

    assign mant  = '{imant_00, imant_01, imant_02, imant_03, imant_04, imant_05, imant_06, imant_07,
                     imant_08, imant_09, imant_10, imant_11, imant_12, imant_13, imant_14, imant_15};
    assign shift = '{ishift_00, ishift_01, ishift_02, ishift_03, ishift_04, ishift_05, ishift_06, ishift_07,
                     ishift_08, ishift_09, ishift_10, ishift_11, ishift_12, ishift_13, ishift_14, ishift_15};

    // A held result freezes the whole pipeline.
    logic stall_c;
    assign stall_c  = out_valid && !out_ready;
    assign in_ready = !rst && !stall_c;

    // ---------------- S1: per-lane alignment ----------------
    logic signed [AW-1:0] al_c [NLANE];

    for (genvar i = 0; i < NLANE; i++) begin : g_lane
        align_shift #(.W(AW), .SHW(EW)) u_lane (
            .d   ({mant[i], {GW{1'b0}}}),
            .sh  (shift[i]),
            .q_c (al_c[i])
        );
    end

    logic signed [AW-1:0] s1_a [NLANE];
    logic [EW-1:0]        s1_exp;
    logic                 s1_last;
    logic                 s1_valid;

    // Capture aligned lanes for the accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_exp   <= '0;
            for (int i = 0; i < NLANE; i++) s1_a[i] <= '0;
        end else if (!stall_c) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            s1_exp   <= iexp_max;
            s1_a     <= al_c;
        end
    end

    // ---------------- S2: 4-level adder tree ----------------
    logic signed [SW-1:0] t1_c [8];
    logic signed [SW-1:0] t2_c [4];
    logic signed [SW-1:0] t3_c [2];
    logic signed [SW-1:0] tree_c;

    // Leaves are sign-extended to the final width, so no level can overflow.
    always_comb begin
        for (int i = 0; i < 8; i++) t1_c[i] = SW'(s1_a[2*i]) + SW'(s1_a[2*i+1]);
        for (int i = 0; i < 4; i++) t2_c[i] = t1_c[2*i] + t1_c[2*i+1];
        for (int i = 0; i < 2; i++) t3_c[i] = t2_c[2*i] + t2_c[2*i+1];
        tree_c = t3_c[0] + t3_c[1];
    end

    tree_beat_t s2_q;
    logic       s2_valid;

    // Register the block sum with its exponent and group flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (!stall_c) begin
            s2_valid  <= s1_valid;
            s2_q.sum  <= tree_c;
            s2_q.bexp <= s1_exp;
            s2_q.last <= s1_last;
        end
    end

    // ---------------- S3: exponent-aligned accumulation ----------------
    logic signed [ACCW-1:0] acc_q;
    logic [EW-1:0]          acc_exp_q;
    logic                   acc_empty_q;

    logic signed [ACCW-1:0] sum_ext_c, acc_sh_c, sum_sh_c, op_a_c, op_b_c, acc_nxt_c;
    logic [EW-1:0]          up_c, dn_c, exp_nxt_c;
    logic                   exp_gt_c;

    assign sum_ext_c = ACCW'($signed(s2_q.sum));
    assign exp_gt_c  = s2_q.bexp > acc_exp_q;
    assign up_c      = s2_q.bexp - acc_exp_q;
    assign dn_c      = acc_exp_q - s2_q.bexp;

    align_shift #(.W(ACCW), .SHW(EW)) u_acc_sh (.d(acc_q),     .sh(up_c), .q_c(acc_sh_c));
    align_shift #(.W(ACCW), .SHW(EW)) u_sum_sh (.d(sum_ext_c), .sh(dn_c), .q_c(sum_sh_c));

    // The operand with the smaller exponent is the one shifted down.
    always_comb begin
        op_a_c    = acc_q;
        op_b_c    = sum_sh_c;
        exp_nxt_c = acc_exp_q;
        if (acc_empty_q) begin
            op_a_c    = '0;
            op_b_c    = sum_ext_c;
            exp_nxt_c = s2_q.bexp;
        end else if (exp_gt_c) begin
            op_a_c    = acc_sh_c;
            op_b_c    = sum_ext_c;
            exp_nxt_c = s2_q.bexp;
        end
        acc_nxt_c = sat_add(op_a_c, op_b_c);
    end

    // Accumulate; on the last beat publish the result and empty the accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            acc_exp_q   <= '0;
            acc_empty_q <= 1'b1;
            out_valid   <= 1'b0;
            osum        <= '0;
            oexp        <= '0;
        end else if (!stall_c) begin
            out_valid <= s2_valid && s2_q.last;
            if (s2_valid) begin
                if (s2_q.last) begin
                    osum        <= acc_nxt_c;
                    oexp        <= exp_nxt_c;
                    acc_empty_q <= 1'b1;
                end else begin
                    acc_q       <= acc_nxt_c;
                    acc_exp_q   <= exp_nxt_c;
                    acc_empty_q <= 1'b0;
                end
            end
        end
    end

endmodule
